// File: rtl/burst_write_arbiter_pkg.sv
// Shared constants and types for the burst write arbiter.
package burst_arb_pkg;

    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned LINE_W    = WORD_W * BURST_LEN;
    localparam int unsigned CNT_W     = $clog2(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_t;

    // Index width that stays at least one bit for a single-entry vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_write_arbiter_if.sv
// Requester-side and downstream burst-port signals of the burst write arbiter.
interface burst_write_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned IN_ADDR_W  = 32,
    parameter int unsigned OUT_ADDR_W = 25,
    parameter int unsigned LINE_W     = 64,
    parameter int unsigned WORD_W     = 16
);
    import burst_arb_pkg::*;

    localparam int unsigned GRANT_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]           req_wr;
    logic [NUM_REQ*IN_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LINE_W-1:0]    req_din;
    logic [NUM_REQ-1:0]           req_wait_n;
    logic                         out_wr;
    logic [OUT_ADDR_W-1:0]        out_addr;
    logic [WORD_W-1:0]            out_din;
    logic                         out_wait_n;
    logic                         out_burst_done;
    logic [GRANT_W-1:0]           grant;
    logic                         busy;

    modport slave (
        input  req_wr, req_addr, req_din, out_wait_n, out_burst_done,
        output req_wait_n, out_wr, out_addr, out_din, grant, busy
    );

    modport master (
        output req_wr, req_addr, req_din, out_wait_n, out_burst_done,
        input  req_wait_n, out_wr, out_addr, out_din, grant, busy
    );

endinterface

// File: rtl/burst_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index,
    output logic [NUM_REQ-1:0] onehot
);

    int unsigned k;

    always_comb begin
        valid  = 1'b0;
        index  = '0;
        onehot = '0;
        k      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = (32'(ptr) + i) % NUM_REQ;
            if (!valid && req[k]) begin
                valid     = 1'b1;
                index     = IDX_W'(k);
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/burst_write_arbiter.sv
// Round-robin arbiter sharing one fixed-length burst write port among line writers.
module burst_write_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned IN_ADDR_W  = 32,
    parameter int unsigned OUT_ADDR_W = 25,
    parameter int unsigned LINE_W     = burst_arb_pkg::LINE_W,
    parameter int unsigned WORD_W     = burst_arb_pkg::WORD_W,
    parameter int unsigned BURST_LEN  = burst_arb_pkg::BURST_LEN
) (
    input logic                 clock,
    input logic                 reset,
    burst_write_arbiter_if.slave bus
);
    import burst_arb_pkg::*;

    localparam int unsigned GRANT_W  = idx_width(NUM_REQ);
    localparam int unsigned CNT_BITS = $clog2(BURST_LEN);
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BURST_LEN - 1);
    localparam logic [GRANT_W-1:0]  LAST_REQ  = GRANT_W'(NUM_REQ - 1);

    state_t                state;
    logic [CNT_BITS-1:0]   cnt;
    logic [GRANT_W-1:0]    ptr;
    logic [GRANT_W-1:0]    grant_r;
    logic [GRANT_W-1:0]    next_ptr;
    logic                  out_wr_r;
    logic                  busy_r;
    logic [OUT_ADDR_W-2:0] addr_reg;
    logic [LINE_W-1:0]     line_reg;

    logic                  pick_valid;
    logic [GRANT_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0]    pick_onehot;
    logic                  accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GRANT_W)
    ) u_rr (
        .req    (bus.req_wr),
        .ptr    (ptr),
        .valid  (pick_valid),
        .index  (pick_idx),
        .onehot (pick_onehot)
    );

    // Accept is gated by reset so a request seen during reset is never consumed.
    assign accept   = (state == IDLE) && pick_valid && !reset;
    assign next_ptr = (grant_r == LAST_REQ) ? '0 : grant_r + GRANT_W'(1);

    assign bus.req_wait_n = accept ? pick_onehot : '0;
    assign bus.out_wr     = out_wr_r;
    assign bus.busy       = busy_r;
    assign bus.grant      = grant_r;
    assign bus.out_addr   = {addr_reg, 1'b0};
    assign bus.out_din    = line_reg[int'(cnt)*WORD_W +: WORD_W];

    // Address bit 0 and bits above the downstream width are never stored.
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_reg <= bus.req_addr[int'(pick_idx)*IN_ADDR_W + 1 +: OUT_ADDR_W - 1];
            line_reg <= bus.req_din[int'(pick_idx)*LINE_W +: LINE_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= '0;
            grant_r  <= '0;
            out_wr_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_r  <= pick_idx;
                        cnt      <= '0;
                        out_wr_r <= 1'b1;
                        busy_r   <= 1'b1;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (bus.out_wait_n) begin
                        cnt <= cnt + CNT_BITS'(1);
                        if (cnt == LAST_BEAT) begin
                            out_wr_r <= 1'b0;
                            if (bus.out_burst_done) begin
                                state  <= IDLE;
                                busy_r <= 1'b0;
                                ptr    <= next_ptr;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_burst_done) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        ptr    <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_write_arbiter.sv
// Directed self-checking bench for burst_write_arbiter with two requesters.
module tb_burst_write_arbiter;

    localparam int unsigned NR  = 2;
    localparam int unsigned IAW = 32;
    localparam int unsigned OAW = 25;
    localparam int unsigned LW  = 64;
    localparam int unsigned WW  = 16;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    burst_write_arbiter_if #(
        .NUM_REQ    (NR),
        .IN_ADDR_W  (IAW),
        .OUT_ADDR_W (OAW),
        .LINE_W     (LW),
        .WORD_W     (WW)
    ) bus ();

    burst_write_arbiter #(
        .NUM_REQ    (NR),
        .IN_ADDR_W  (IAW),
        .OUT_ADDR_W (OAW),
        .LINE_W     (LW),
        .WORD_W     (WW),
        .BURST_LEN  (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic set_req(input int unsigned i, input logic [31:0] addr, input logic [63:0] din);
        bus.req_addr[i*IAW +: IAW] = addr;
        bus.req_din[i*LW +: LW]    = din;
    endtask

    // Completes the current burst, pulsing done while draining; returns at an idle negedge+1.
    task automatic finish_burst(output bit ok);
        ok = 1'b0;
        for (int unsigned t = 0; t < 20 && !ok; t++) begin
            @(negedge clock);
            bus.out_wait_n     = 1'b1;
            bus.out_burst_done = bus.busy && !bus.out_wr;
            #1;
            if (!bus.busy) ok = 1'b1;
        end
        bus.out_burst_done = 1'b0;
    endtask

    task automatic test_reset;
        reset              = 1'b1;
        bus.req_wr         = '0;
        bus.req_addr       = '0;
        bus.req_din        = '0;
        bus.out_wait_n     = 1'b1;
        bus.out_burst_done = 1'b0;
        repeat (3) @(negedge clock);
        bus.req_wr = 2'b01;
        #1;
        checks++; if (bus.req_wait_n !== 2'b00) begin errors++; $display("FAIL reset_wait_n: got %b want 00", bus.req_wait_n); end
        checks++; if (bus.out_wr !== 1'b0) begin errors++; $display("FAIL reset_out_wr: got %b want 0", bus.out_wr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", bus.grant); end
        bus.req_wr = '0;
        reset      = 1'b0;
    endtask

    task automatic test_single;
        logic [15:0] exp_w[4];
        bit ok;
        exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        @(negedge clock);
        set_req(0, 32'h0000_1235, 64'h4444_3333_2222_1111);
        bus.req_wr = 2'b01;
        #1;
        checks++; if (bus.req_wait_n !== 2'b01) begin errors++; $display("FAIL single_accept: got %b want 01", bus.req_wait_n); end
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clock);
            bus.req_wr = '0;
            #1;
            checks++; if (bus.out_wr !== 1'b1) begin errors++; $display("FAIL single_wr beat%0d: got %b want 1", k, bus.out_wr); end
            checks++; if (bus.out_din !== exp_w[k]) begin errors++; $display("FAIL single_din beat%0d: got %h want %h", k, bus.out_din, exp_w[k]); end
            checks++; if (bus.req_wait_n !== 2'b00) begin errors++; $display("FAIL single_stall beat%0d: got %b want 00", k, bus.req_wait_n); end
            if (k == 0) begin
                checks++; if (bus.out_addr !== 25'h000_1234) begin errors++; $display("FAIL single_addr: got %h want 0001234", bus.out_addr); end
                checks++; if (bus.grant !== 1'b0) begin errors++; $display("FAIL single_grant: got %b want 0", bus.grant); end
            end
        end
        repeat (2) begin
            @(negedge clock);
            #1;
            checks++; if (bus.out_wr !== 1'b0) begin errors++; $display("FAIL single_drain_wr: got %b want 0", bus.out_wr); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_drain_busy: got %b want 1", bus.busy); end
        end
        @(negedge clock);
        bus.out_burst_done = 1'b1;
        @(negedge clock);
        bus.out_burst_done = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", bus.busy); end
        finish_burst(ok);
    endtask

    task automatic test_backpressure;
        logic        wn[7];
        logic [15:0] exp_d[7];
        int          burst_cycles;
        bit          ok;
        wn    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_d = '{16'h1111, 16'h2222, 16'h2222, 16'h2222, 16'h2222, 16'h3333, 16'h4444};
        burst_cycles = 0;
        @(negedge clock);
        set_req(0, 32'h0000_0100, 64'h4444_3333_2222_1111);
        bus.req_wr = 2'b01;
        #1;
        checks++; if (bus.req_wait_n !== 2'b01) begin errors++; $display("FAIL bp_accept: got %b want 01", bus.req_wait_n); end
        for (int unsigned c = 0; c < 7; c++) begin
            @(negedge clock);
            bus.req_wr     = '0;
            bus.out_wait_n = wn[c];
            #1;
            if (bus.out_wr === 1'b1) burst_cycles++;
            checks++; if (bus.out_din !== exp_d[c]) begin errors++; $display("FAIL bp_din cyc%0d: got %h want %h", c, bus.out_din, exp_d[c]); end
        end
        @(negedge clock);
        bus.out_wait_n = 1'b1;
        #1;
        checks++; if (bus.out_wr !== 1'b0) begin errors++; $display("FAIL bp_end_wr: got %b want 0", bus.out_wr); end
        checks++; if (burst_cycles != 7) begin errors++; $display("FAIL bp_cycles: got %0d want 7", burst_cycles); end
        finish_burst(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_finish: got timeout want idle"); end
    endtask

    task automatic test_contention;
        logic [1:0]  exp_oh[4];
        logic        exp_g[4];
        logic [24:0] exp_a[4];
        bit          found;
        bit          ok;
        exp_oh = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_g  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_a  = '{25'h000_4000, 25'h000_5000, 25'h000_4000, 25'h000_5000};
        @(negedge clock);
        reset = 1'b1;
        set_req(0, 32'h0000_4000, 64'hA003_A002_A001_A000);
        set_req(1, 32'h0000_5000, 64'hB003_B002_B001_B000);
        @(negedge clock);
        reset      = 1'b0;
        bus.req_wr = 2'b11;
        for (int unsigned b = 0; b < 4; b++) begin
            found = 1'b0;
            for (int unsigned t = 0; t < 20 && !found; t++) begin
                bus.out_burst_done = bus.busy && !bus.out_wr;
                #1;
                if (bus.req_wait_n !== 2'b00) found = 1'b1;
                else @(negedge clock);
            end
            checks++; if (!found) begin errors++; $display("FAIL cont_timeout b%0d: got none want accept", b); end
            checks++; if (bus.req_wait_n !== exp_oh[b]) begin errors++; $display("FAIL cont_wait_n b%0d: got %b want %b", b, bus.req_wait_n, exp_oh[b]); end
            @(negedge clock);
            bus.out_burst_done = 1'b0;
            if (b == 3) bus.req_wr = '0;
            #1;
            checks++; if (bus.grant !== exp_g[b]) begin errors++; $display("FAIL cont_grant b%0d: got %b want %b", b, bus.grant, exp_g[b]); end
            checks++; if (bus.out_addr !== exp_a[b]) begin errors++; $display("FAIL cont_addr b%0d: got %h want %h", b, bus.out_addr, exp_a[b]); end
            if (b < 3) @(negedge clock);
        end
        finish_burst(ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_finish: got timeout want idle"); end
    endtask

    task automatic test_done_on_last;
        logic [15:0] exp_w[4];
        bit ok;
        exp_w = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
        @(negedge clock);
        set_req(1, 32'h0000_6000, 64'h8888_7777_6666_5555);
        set_req(0, 32'h0000_7000, 64'hC003_C002_C001_C000);
        bus.req_wr = 2'b10;
        #1;
        checks++; if (bus.req_wait_n !== 2'b10) begin errors++; $display("FAIL dol_accept: got %b want 10", bus.req_wait_n); end
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clock);
            bus.req_wr = '0;
            if (k == 3) begin
                bus.out_burst_done = 1'b1;
                bus.req_wr         = 2'b01;
            end
            #1;
            checks++; if (bus.out_din !== exp_w[k]) begin errors++; $display("FAIL dol_din beat%0d: got %h want %h", k, bus.out_din, exp_w[k]); end
            if (k == 3) begin
                checks++; if (bus.req_wait_n !== 2'b00) begin errors++; $display("FAIL dol_stall: got %b want 00", bus.req_wait_n); end
            end
        end
        @(negedge clock);
        bus.out_burst_done = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dol_no_drain: got %b want 0", bus.busy); end
        checks++; if (bus.req_wait_n !== 2'b01) begin errors++; $display("FAIL dol_next_accept: got %b want 01", bus.req_wait_n); end
        @(negedge clock);
        bus.req_wr = '0;
        #1;
        checks++; if (bus.out_wr !== 1'b1) begin errors++; $display("FAIL dol_next_wr: got %b want 1", bus.out_wr); end
        checks++; if (bus.out_din !== 16'hC000) begin errors++; $display("FAIL dol_next_din: got %h want c000", bus.out_din); end
        finish_burst(ok);
    endtask

    task automatic test_spurious_done;
        logic [15:0] exp_w[4];
        bit ok;
        exp_w = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        @(negedge clock);
        bus.out_burst_done = 1'b1;
        #1;
        @(negedge clock);
        bus.out_burst_done = 1'b0;
        set_req(0, 32'h0000_2000, 64'hDDDD_CCCC_BBBB_AAAA);
        bus.req_wr = 2'b01;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL spur_idle_busy: got %b want 0", bus.busy); end
        checks++; if (bus.req_wait_n !== 2'b01) begin errors++; $display("FAIL spur_accept: got %b want 01", bus.req_wait_n); end
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clock);
            bus.req_wr         = '0;
            bus.out_burst_done = (k == 0);
            #1;
            checks++; if (bus.out_wr !== 1'b1) begin errors++; $display("FAIL spur_wr beat%0d: got %b want 1", k, bus.out_wr); end
            checks++; if (bus.out_din !== exp_w[k]) begin errors++; $display("FAIL spur_din beat%0d: got %h want %h", k, bus.out_din, exp_w[k]); end
        end
        @(negedge clock);
        bus.out_burst_done = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL spur_drain: got %b want 1", bus.busy); end
        finish_burst(ok);
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        @(negedge clock);
        set_req(0, 32'h0000_3000, 64'h4D4D_3D3D_2D2D_1D1D);
        set_req(1, 32'h0000_3800, 64'h4E4E_3E3E_2E2E_1E1E);
        bus.req_wr = 2'b01;
        #1;
        checks++; if (bus.req_wait_n !== 2'b01) begin errors++; $display("FAIL rst_accept: got %b want 01", bus.req_wait_n); end
        repeat (2) begin
            @(negedge clock);
            bus.req_wr = '0;
        end
        @(negedge clock);
        reset      = 1'b1;
        bus.req_wr = 2'b10;
        #1;
        checks++; if (bus.out_din !== 16'h3D3D) begin errors++; $display("FAIL rst_beat3: got %h want 3d3d", bus.out_din); end
        checks++; if (bus.req_wait_n !== 2'b00) begin errors++; $display("FAIL rst_stall: got %b want 00", bus.req_wait_n); end
        @(negedge clock);
        #1;
        checks++; if (bus.out_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b want 0", bus.out_wr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.grant !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b want 0", bus.grant); end
        reset      = 1'b0;
        bus.req_wr = 2'b11;
        #1;
        checks++; if (bus.req_wait_n !== 2'b01) begin errors++; $display("FAIL rst_ptr: got %b want 01", bus.req_wait_n); end
        @(negedge clock);
        bus.req_wr = 2'b10;
        #1;
        checks++; if (bus.out_addr !== 25'h000_3000) begin errors++; $display("FAIL rst_addr: got %h want 0003000", bus.out_addr); end
        finish_burst(ok);
        checks++; if (bus.req_wait_n !== 2'b10) begin errors++; $display("FAIL rst_req1_next: got %b want 10", bus.req_wait_n); end
        @(negedge clock);
        bus.req_wr = '0;
        #1;
        checks++; if (bus.grant !== 1'b1) begin errors++; $display("FAIL rst_req1_grant: got %b want 1", bus.grant); end
        checks++; if (bus.out_din !== 16'h1E1E) begin errors++; $display("FAIL rst_req1_din: got %h want 1e1e", bus.out_din); end
        finish_burst(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_finish: got timeout want idle"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_contention();
        test_done_on_last();
        test_spurious_done();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/burst_write_arbiter.md
Name: burst_write_arbiter

Overview:
- Shares one downstream burst write port (16-bit words, fixed 4-word bursts) between NUM_REQ requesters; each requester offers one 64-bit line per request.
- Round-robin grant, latches the line, sequences the 4 beats, then waits for burst completion before re-arbitrating.
- Sits between the frame/sprite line writers and the DDR/SDRAM burst write channel.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- IN_ADDR_W, 32, requester byte address width.
- OUT_ADDR_W, 25, downstream byte address width.
- LINE_W, 64, requester data width; equals WORD_W*BURST_LEN.
- WORD_W, 16, downstream data width.
- BURST_LEN, 4, beats per burst (power of two).

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_wr  in  NUM_REQ  per-requester write request, held until accepted.
- req_addr  in  NUM_REQ*IN_ADDR_W  packed addresses, requester i at [i*IN_ADDR_W +: IN_ADDR_W].
- req_din  in  NUM_REQ*LINE_W  packed line data, same packing.
- req_wait_n  out  NUM_REQ  one-hot accept strobe; 1 only in the accept cycle of that requester.
- out_wr  out  1  burst write active.
- out_addr  out  OUT_ADDR_W  burst start address, bit 0 forced 0.
- out_din  out  WORD_W  current beat data.
- out_wait_n  in  1  downstream accepts beat when 1 with out_wr.
- out_burst_done  in  1  downstream burst complete pulse.
- grant  out  $clog2(NUM_REQ)  index of requester owning current burst.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: out_wr=0, req_wait_n=0, busy=0, grant=0, beat counter=0, round-robin pointer=0, state=IDLE. out_addr/out_din data registers not reset.
- States: IDLE, BURST, DRAIN.
- IDLE: candidate = first i with req_wr[i]=1 searching from pointer upward, wrapping modulo NUM_REQ. If a candidate exists: req_wait_n[candidate]=1 combinationally in this cycle; latch addr -> addrReg, din -> line register, grant <= candidate, counter <= 0; next state BURST. No candidate: all req_wait_n=0, stay.
- Accept is combinational on req_wr: a requester sees req_wait_n high in the same cycle it drives req_wr; its request is consumed on that edge.
- BURST: out_wr=1; out_addr={addrReg[OUT_ADDR_W-1:1],1'b0} (upper address bits dropped); out_din=line[counter*WORD_W +: WORD_W], word 0 = bits [15:0]. counter increments on out_wait_n=1. Last beat (counter=BURST_LEN-1) with out_wait_n=1: go DRAIN, or IDLE if out_burst_done=1 in the same cycle.
- DRAIN: out_wr=0; on out_burst_done go IDLE.
- Pointer update: on every transition into IDLE, pointer <= grant+1 mod NUM_REQ, so the just-served requester has lowest priority.
- out_burst_done in IDLE, or in BURST before the last beat is accepted: ignored; no state or counter change.
- out_wait_n=0 during BURST: beat and out_din held stable, out_wr stays 1.
- Latency: accept edge -> out_wr=1 next cycle; minimum 4 BURST cycles; earliest next accept is the cycle after the state returns to IDLE.
- All req_wait_n=0 outside IDLE; requesters stall.
- Reset mid-burst: out_wr=0 next cycle, burst abandoned, pointer=0; the pending requester is not acknowledged.
- Counter is log2(BURST_LEN) bits, natural wrap; it is cleared on accept.

Decomposition:
- Package burst_arb_pkg: BURST_LEN, WORD_W, LINE_W constants; state enum {IDLE, BURST, DRAIN}; counter width constant.
- Sub-module rr_arbiter: purely combinational priority picker (req vector, pointer) -> (valid, index, one-hot). Used once; the FSM and datapath stay in the top module.

Test Plan:
- Single request: req0 wr, addr=0x0000_1235, din=0x4444_3333_2222_1111, out_wait_n=1 -> req_wait_n=01 for 1 cycle; out_addr=0x1234; beats 0x1111,0x2222,0x3333,0x4444 on consecutive cycles; out_wr low after beat 4 until done; then IDLE.
- Backpressure: out_wait_n low on beat 2 for 3 cycles -> out_din holds 0x2222, out_wr stays 1, total 7 BURST cycles.
- Contention: req0 and req1 held continuously -> grants alternate 0,1,0,1 across 4 bursts; neither requester is starved.
- Done on last beat: out_burst_done=1 with beat 4 accepted -> state goes straight to IDLE; no DRAIN cycle; next accept the following cycle.
- Spurious done: out_burst_done pulse in IDLE and on beat 1 -> no state change; all 4 beats are still emitted.
- Reset during beat 3 -> out_wr=0 next cycle, busy=0, grant=0; after reset release, a held req1 is accepted first only if req0 is idle (pointer=0).
